accum_array: RTL

ACCUM_ARRAY -- requirements
Module: accum_array

---
 rtl/accum_pkg.sv | 14 +
 rtl/accum_ram.sv | 22 ++
 rtl/accum_array.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared types and widths for the counter accumulation array.
package accum_pkg;
    localparam int COUNTER_W = 64;
    localparam int LANES     = 8;
    localparam int AXIS_W    = 512;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        CLEAR,
        DUMP_RD,
        DUMP_OUT
    } state_e;
endpackage

// File: rtl/accum_ram.sv
// Counter storage: simple dual-port RAM, one read and one write port, registered read.
module accum_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int W      = 64
) (
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [W-1:0]      rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [W-1:0]      wr_data_i
);
    logic [W-1:0] mem [DEPTH];

    // Read-first on a same-address collision; the caller forwards around it.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem[rd_addr_i];
    end
endmodule

// File: rtl/accum_array.sv
// Array of 64-bit counters with a 2-stage increment pipeline, bulk clear and AXI-stream dump.
module accum_array
    import accum_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       accum_addr,
    input  logic [63:0]       accum_din,
    input  logic              accum_we,
    input  logic              clear_kick,
    input  logic              dump_kick,
    input  logic [31:0]       dump_words,
    output logic              busy,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [31:0]       drop_count
);
    // Dump pointer/count need room for DEPTH plus one beat of overrun.
    localparam int PW = ADDR_W + 2;

    state_e                          state_q, tgt_q;
    logic                            busy_q;
    logic [ADDR_W-1:0]               clr_q;
    logic [PW-1:0]                   cnt_q, ptr_q;
    logic [3:0]                      sub_q;
    logic                            cap_q, keep_q;
    logic [2:0]                      lane_q;
    logic [LANES-1:0][COUNTER_W-1:0] tdata_q;
    logic                            tvalid_q, tlast_q;
    logic [31:0]                     drop_q;

    logic                            s1_vld_q, s2_vld_q;
    logic [ADDR_W-1:0]               s1_addr_q, s2_addr_q;
    logic [COUNTER_W-1:0]            s1_din_q, s2_data_q;

    logic                            acc_ok, acc_drop, dump_rd;
    logic [PW-1:0]                   dump_idx;
    logic [COUNTER_W-1:0]            rd_data, base, sum;
    logic                            rd_en, wr_en;
    logic [ADDR_W-1:0]               rd_addr, wr_addr;
    logic [COUNTER_W-1:0]            wr_data;

    assign acc_ok   = accum_we && (accum_addr < 32'(DEPTH)) && (state_q == IDLE);
    assign acc_drop = accum_we && !acc_ok;
    assign dump_idx = ptr_q + PW'(sub_q);
    assign dump_rd  = (state_q == DUMP_RD) && !sub_q[3];

    // The write committed on the same edge as our read is invisible to the RAM; take it from s2.
    assign base = (s2_vld_q && s2_addr_q == s1_addr_q) ? s2_data_q : rd_data;
    assign sum  = base + s1_din_q;

    assign rd_en   = acc_ok || dump_rd;
    assign rd_addr = (state_q == IDLE) ? accum_addr[ADDR_W-1:0] : dump_idx[ADDR_W-1:0];
    assign wr_en   = (state_q == CLEAR) || s1_vld_q;
    assign wr_addr = (state_q == CLEAR) ? clr_q : s1_addr_q;
    assign wr_data = (state_q == CLEAR) ? '0 : sum;

    accum_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(COUNTER_W)) u_ram (
        .clk       (clk),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= acc_ok;
            s2_vld_q <= s1_vld_q;
        end
        s1_addr_q <= accum_addr[ADDR_W-1:0];
        s1_din_q  <= accum_din;
        s2_addr_q <= s1_addr_q;
        s2_data_q <= sum;
    end

    always_ff @(posedge clk) begin
        if (reset)                         drop_q <= '0;
        else if (acc_drop && drop_q != '1) drop_q <= drop_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            tgt_q    <= CLEAR;
            busy_q   <= 1'b1;
            clr_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            sub_q    <= '0;
            cap_q    <= 1'b0;
            keep_q   <= 1'b0;
            lane_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            cap_q  <= dump_rd;
            lane_q <= sub_q[2:0];
            keep_q <= dump_idx < cnt_q;
            if (cap_q) tdata_q[lane_q] <= keep_q ? rd_data : '0;

            case (state_q)
                IDLE: begin
                    if (clear_kick) begin
                        state_q <= FLUSH;
                        tgt_q   <= CLEAR;
                        busy_q  <= 1'b1;
                        clr_q   <= '0;
                    end else if (dump_kick) begin
                        state_q <= FLUSH;
                        tgt_q   <= DUMP_RD;
                        busy_q  <= 1'b1;
                        cnt_q   <= (dump_words >= 32'(DEPTH)) ? PW'(DEPTH) : dump_words[PW-1:0];
                        ptr_q   <= '0;
                        sub_q   <= '0;
                    end
                end
                FLUSH: begin
                    if (!s1_vld_q) begin
                        if (tgt_q == DUMP_RD && cnt_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= tgt_q;
                        end
                    end
                end
                CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                DUMP_RD: begin
                    // sub_q==8: last lane lands in tdata on this edge.
                    if (!sub_q[3]) begin
                        sub_q <= sub_q + 4'd1;
                    end else begin
                        state_q  <= DUMP_OUT;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (ptr_q + PW'(8)) >= cnt_q;
                        ptr_q    <= ptr_q + PW'(8);
                    end
                end
                DUMP_OUT: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        sub_q    <= '0;
                        if (tlast_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DUMP_RD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign drop_count    = drop_q;
endmodule
